conv_inst_expander: RTL



---
 rtl/conv_inst_expander.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/conv_inst_expander.sv
// Expands one packed conv instruction bundle into KxK kernel-tap beats, offsetting the
// base field of the masked slots by dilation*(row*dim0 + col); registered valid/ready output.
module conv_inst_expander #(
    parameter int IRW = 30,
    parameter int IN = 3,
    parameter int AW = 14,
    parameter int DW0 = 7,
    parameter int KMAX = 7,
    parameter logic [IN-1:0] SLOT_MASK = 3'b001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IRW*IN-1:0] m_inst,
    input  logic              m_valid,
    output logic              m_ready,
    output logic [IRW*IN-1:0] s_inst,
    output logic              s_valid,
    input  logic              s_ready,
    output logic              s_last
);

    localparam int BW = IRW * IN;
    localparam int K_LO = AW + DW0 + 1;
    localparam logic [2:0] KMAX_C = 3'(KMAX);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [BW-1:0]   bundle_r, bundle_nxt_s;
    logic [2:0]      k_r, k_nxt_s;
    logic [2:0]      row_r, row_nxt_s;
    logic [2:0]      col_r, col_nxt_s;
    logic [AW-1:0]   col_step_r, col_step_nxt_s;
    logic [AW-1:0]   row_step_r, row_step_nxt_s;
    logic [AW-1:0]   row_off_r, row_off_nxt_s;
    logic [AW-1:0]   col_off_r, col_off_nxt_s;
    logic [BW-1:0]   s_inst_r, s_inst_nxt_s;
    logic            s_valid_r, s_valid_nxt_s;
    logic            s_last_r, s_last_nxt_s;

    logic            m_ready_s;
    logic            accept_s;
    logic            out_hs_s;
    logic [2:0]      k_raw_s;
    logic [2:0]      k_eff_s;
    logic [AW-1:0]   dim0_ext_s;
    logic            dil_s;
    logic            expand_s;
    logic            row_wrap_s;

    // Adds the tap offset to the base field of every masked slot; other bits pass unchanged.
    function automatic logic [BW-1:0] apply_offset(input logic [BW-1:0] bundle,
                                                   input logic [AW-1:0] off);
        logic [BW-1:0] res;
        res = bundle;
        for (int i = 0; i < IN; i++) begin
            if (SLOT_MASK[i]) begin
                res[i*IRW+1 +: AW] = bundle[i*IRW+1 +: AW] + off;
            end
        end
        return res;
    endfunction

    assign m_ready = m_ready_s;
    assign s_inst  = s_inst_r;
    assign s_valid = s_valid_r;
    assign s_last  = s_last_r;

    // Decode of the incoming bundle and handshake qualifiers.
    always_comb begin
        // A consumed final beat frees the stage in the same cycle, so the next bundle has no bubble.
        m_ready_s  = ((state_r == IDLE) && (!s_valid_r || s_ready)) ||
                     ((state_r == EXPAND) && s_valid_r && s_last_r && s_ready);
        accept_s   = m_valid && m_ready_s;
        out_hs_s   = s_valid_r && s_ready;
        k_raw_s    = m_inst[K_LO+2:K_LO];
        dim0_ext_s = {{(AW-DW0){1'b0}}, m_inst[AW+DW0:AW+1]};
        dil_s      = m_inst[AW+DW0+4];
        if (k_raw_s < 3'd2) begin
            k_eff_s = 3'd1;
        end else if (k_raw_s > KMAX_C) begin
            k_eff_s = KMAX_C;
        end else begin
            k_eff_s = k_raw_s;
        end
        expand_s   = m_inst[0] && (k_eff_s != 3'd1);
        row_wrap_s = (col_r == (k_r - 3'd1));
    end

    // Next-state, counter and output-register computation.
    always_comb begin
        state_nxt_s    = state_r;
        bundle_nxt_s   = bundle_r;
        k_nxt_s        = k_r;
        row_nxt_s      = row_r;
        col_nxt_s      = col_r;
        col_step_nxt_s = col_step_r;
        row_step_nxt_s = row_step_r;
        row_off_nxt_s  = row_off_r;
        col_off_nxt_s  = col_off_r;
        s_inst_nxt_s   = s_inst_r;
        s_valid_nxt_s  = s_valid_r;
        s_last_nxt_s   = s_last_r;
        if (accept_s) begin
            bundle_nxt_s   = m_inst;
            s_inst_nxt_s   = m_inst;
            s_valid_nxt_s  = 1'b1;
            k_nxt_s        = k_eff_s;
            row_nxt_s      = 3'd0;
            col_nxt_s      = 3'd0;
            row_off_nxt_s  = {AW{1'b0}};
            col_off_nxt_s  = {AW{1'b0}};
            col_step_nxt_s = dil_s ? {{(AW-2){1'b0}}, 2'd2} : {{(AW-1){1'b0}}, 1'b1};
            row_step_nxt_s = dil_s ? {dim0_ext_s[AW-2:0], 1'b0} : dim0_ext_s;
            if (expand_s) begin
                state_nxt_s  = EXPAND;
                s_last_nxt_s = 1'b0;
            end else begin
                state_nxt_s  = IDLE;
                s_last_nxt_s = 1'b1;
            end
        end else if (out_hs_s) begin
            case (state_r)
                EXPAND: begin
                    if (!s_last_r) begin
                        // Row step reloads from the row-start accumulator; no multiplier needed.
                        if (row_wrap_s) begin
                            row_nxt_s     = row_r + 3'd1;
                            col_nxt_s     = 3'd0;
                            row_off_nxt_s = row_off_r + row_step_r;
                            col_off_nxt_s = row_off_r + row_step_r;
                        end else begin
                            col_nxt_s     = col_r + 3'd1;
                            col_off_nxt_s = col_off_r + col_step_r;
                        end
                        s_inst_nxt_s = apply_offset(bundle_r, col_off_nxt_s);
                        s_last_nxt_s = (row_nxt_s == (k_r - 3'd1)) && (col_nxt_s == (k_r - 3'd1));
                    end else begin
                        state_nxt_s   = IDLE;
                        s_valid_nxt_s = 1'b0;
                        s_last_nxt_s  = 1'b0;
                    end
                end
                IDLE: begin
                    s_valid_nxt_s = 1'b0;
                    s_last_nxt_s  = 1'b0;
                end
                default: begin
                    state_nxt_s   = IDLE;
                    s_valid_nxt_s = 1'b0;
                    s_last_nxt_s  = 1'b0;
                end
            endcase
        end else begin
            s_valid_nxt_s = s_valid_r;
        end
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            bundle_r   <= {BW{1'b0}};
            k_r        <= 3'd0;
            row_r      <= 3'd0;
            col_r      <= 3'd0;
            col_step_r <= {AW{1'b0}};
            row_step_r <= {AW{1'b0}};
            row_off_r  <= {AW{1'b0}};
            col_off_r  <= {AW{1'b0}};
            s_inst_r   <= {BW{1'b0}};
            s_valid_r  <= 1'b0;
            s_last_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            bundle_r   <= bundle_nxt_s;
            k_r        <= k_nxt_s;
            row_r      <= row_nxt_s;
            col_r      <= col_nxt_s;
            col_step_r <= col_step_nxt_s;
            row_step_r <= row_step_nxt_s;
            row_off_r  <= row_off_nxt_s;
            col_off_r  <= col_off_nxt_s;
            s_inst_r   <= s_inst_nxt_s;
            s_valid_r  <= s_valid_nxt_s;
            s_last_r   <= s_last_nxt_s;
        end
    end

endmodule
